// File: rtl/shift_ctrl.sv
// shift_ctrl: four-state shift sequencer (IDLE/LOAD/SHIFT/WB) that decodes shifter controls from the latched op.
module shift_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    input  logic       stall,
    input  logic       amt_zero,
    output logic [1:0] ShiftAmt,
    output logic       ShiftSrc,
    output logic [2:0] Shift,
    output logic       wb_en,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WB} state_t;
    state_t     state, state_n;
    logic [2:0] op_q, dir;
    logic [1:0] amt_sel;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op_q  <= 3'b000;
        end else begin
            state <= state_n;
            if (state == IDLE && start) op_q <= op;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? LOAD : IDLE;
            LOAD:    state_n = stall ? LOAD : (amt_zero ? WB : SHIFT);
            SHIFT:   state_n = stall ? SHIFT : WB;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        dir      = (op_q == 3'd0 || op_q == 3'd3 || op_q == 3'd6) ? 3'b010 :
                   (op_q == 3'd1 || op_q == 3'd4) ? 3'b011 : 3'b100;
        amt_sel  = (op_q < 3'd3) ? 2'b01 : (op_q < 3'd6) ? 2'b00 :
                   (op_q == 3'd6) ? 2'b11 : 2'b10;
        busy     = state != IDLE && !reset;
        ShiftAmt = busy ? amt_sel : 2'b00;
        ShiftSrc = busy && op_q == 3'd6;
        Shift    = (reset || stall) ? 3'b000 :
                   (state == LOAD) ? 3'b001 :
                   (state == SHIFT) ? dir : 3'b000;
        wb_en    = state == WB && !reset;
        done     = wb_en;
    end
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed cycle table plus randomized run against a step-tracking reference model.
module tb_shift_ctrl;
    logic       clk = 1'b0;
    logic       reset, start, stall, amt_zero;
    logic [2:0] op;
    logic [1:0] ShiftAmt;
    logic       ShiftSrc, wb_en, busy, done;
    logic [2:0] Shift;
    int checks = 0;
    int errors = 0;

    shift_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .stall(stall),
        .amt_zero(amt_zero), .ShiftAmt(ShiftAmt), .ShiftSrc(ShiftSrc),
        .Shift(Shift), .wb_en(wb_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       s;
        logic [2:0] o;
        logic       st;
        logic       az;
        logic [8:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [2:0] dir_tab [8] = '{3'b010, 3'b011, 3'b100, 3'b010, 3'b011, 3'b100, 3'b010, 3'b100};
    logic [1:0] amt_tab [8] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10};

    bit         m_active, m_loaded, m_shifted;
    logic [2:0] m_op;
    int         exp_dones, got_dones;

    function automatic logic [8:0] outs();
        return {ShiftAmt, ShiftSrc, Shift, wb_en, busy, done};
    endfunction

    task automatic add(input logic r, s, input logic [2:0] o, input logic st, az, input logic [8:0] e);
        vecs.push_back('{r, s, o, st, az, e});
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got amt/src/shift/wb/busy/done=%b required %b", name, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; stall = 1'b0; amt_zero = 1'b0;
        // {ShiftAmt, ShiftSrc, Shift, wb_en, busy, done}
        add(1, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(1, 1, 5, 1, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b01_0_001_0_1_0);
        add(0, 0, 0, 0, 0, 9'b01_0_010_0_1_0);
        add(0, 0, 0, 0, 0, 9'b01_0_000_1_1_1);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 6, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b11_1_001_0_1_0);
        add(0, 0, 0, 0, 0, 9'b11_1_010_0_1_0);
        add(0, 0, 0, 0, 0, 9'b11_1_000_1_1_1);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 5, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 1, 9'b00_0_001_0_1_0);
        add(0, 0, 0, 0, 0, 9'b00_0_000_1_1_1);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 7, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b10_0_001_0_1_0);
        add(0, 0, 0, 1, 0, 9'b10_0_000_0_1_0);
        add(0, 0, 0, 1, 0, 9'b10_0_000_0_1_0);
        add(0, 0, 0, 0, 0, 9'b10_0_100_0_1_0);
        add(0, 0, 0, 0, 0, 9'b10_0_000_1_1_1);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 1, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b01_0_001_0_1_0);
        add(1, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 4, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b00_0_001_0_1_0);
        add(0, 0, 0, 0, 0, 9'b00_0_011_0_1_0);
        add(0, 0, 0, 0, 0, 9'b00_0_000_1_1_1);
        add(0, 1, 3, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 6, 0, 0, 9'b00_0_001_0_1_0);
        add(0, 0, 6, 0, 0, 9'b00_0_010_0_1_0);
        add(0, 1, 7, 0, 0, 9'b00_0_000_1_1_1);
        add(0, 0, 7, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 1, 2, 0, 0, 9'b00_0_000_0_0_0);
        add(0, 0, 0, 1, 1, 9'b01_0_000_0_1_0);
        add(0, 0, 0, 0, 0, 9'b01_0_001_0_1_0);
        add(0, 0, 0, 0, 0, 9'b01_0_100_0_1_0);
        add(0, 0, 0, 1, 0, 9'b01_0_000_1_1_1);
        add(0, 0, 0, 1, 0, 9'b00_0_000_0_0_0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].r; start = vecs[i].s; op = vecs[i].o;
            stall = vecs[i].st; amt_zero = vecs[i].az;
            #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Random run: model tracks which steps of the accepted op are complete.
        m_active = 0; m_loaded = 0; m_shifted = 0; m_op = 3'b000;
        exp_dones = 0; got_dones = 0;
        @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 3000; c++) begin
            logic [8:0] e;
            logic [2:0] sh;
            @(negedge clk);
            reset    = ($urandom_range(0, 63) == 0);
            start    = ($urandom_range(0, 3) != 0);
            op       = 3'($urandom_range(0, 7));
            stall    = ($urandom_range(0, 3) == 0);
            amt_zero = ($urandom_range(0, 3) == 0);
            e = '0;
            if (!reset && m_active) begin
                sh = 3'b000;
                if (!m_loaded) sh = stall ? 3'b000 : 3'b001;
                else if (!m_shifted) sh = stall ? 3'b000 : dir_tab[m_op];
                e = {amt_tab[m_op], m_op == 3'd6, sh, m_loaded && m_shifted, 1'b1, m_loaded && m_shifted};
                if (m_loaded && m_shifted) exp_dones++;
            end
            #1 check($sformatf("rand%0d", c), outs(), e);
            if (done) got_dones++;
            @(posedge clk);
            if (reset) begin
                m_active = 0; m_loaded = 0; m_shifted = 0; m_op = 3'b000;
            end else if (!m_active) begin
                if (start) begin m_active = 1; m_op = op; end
            end else if (!m_loaded) begin
                if (!stall) begin m_loaded = 1; m_shifted = amt_zero; end
            end else if (!m_shifted) begin
                if (!stall) m_shifted = 1;
            end else begin
                m_active = 0; m_loaded = 0; m_shifted = 0;
            end
        end
        checks++;
        if (got_dones != exp_dones || exp_dones == 0) begin
            errors++;
            $display("FAIL done_count: got %0d required %0d (nonzero)", got_dones, exp_dones);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
